seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-select 7-segment display.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_cyc_timer.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    // Decoder mode codes
    localparam logic [1:0] MODE_DEC_X   = 2'b00;
    localparam logic [1:0] MODE_DEC_OFF = 2'b01;
    localparam logic [1:0] MODE_DEC_ON  = 2'b10;
    localparam logic [1:0] MODE_HEX     = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // One digit's programmable state
    typedef struct packed {
        logic [3:0] data;
        logic [1:0] mode;
        logic       blink;
    } digit_t;

    localparam digit_t DIGIT_RST = '{data: 4'd0, mode: MODE_DEC_OFF, blink: 1'b0};

endpackage

// File: rtl/seg_cyc_timer.sv
// Loadable down-counter that saturates at zero; times SHOW and BLANK intervals.
module seg_cyc_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic         done_o,
    output logic         done_nxt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear beats load, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (ld_i)
            cnt_d = ld_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // done_nxt lets the caller register outputs that line up with the last cycle
    assign done_o     = (cnt_q == '0);
    assign done_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: digit register file, scan FSM, blink timing and registered
// drive for one shared seven-segment decoder plus active-low digit selects.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 5000,
    parameter int BLANK_CYC = 50,
    parameter int BLINK_DIV = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_addr_i,
    input  logic [3:0]       wr_data_i,
    input  logic [1:0]       wr_mode_i,
    input  logic             wr_blink_i,
    output logic [3:0]       dec_data_o,
    output logic [1:0]       dec_mode_o,
    output logic             dec_en_o,
    output logic [N_DIG-1:0] dig_sel_n_o,
    output logic             frame_done_o
);

    localparam int TMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int TW   = $clog2(TMAX);
    localparam int PW   = $clog2(N_DIG);
    localparam int FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] SHOW_LD  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
    localparam logic [PW-1:0] LAST     = PW'(N_DIG - 1);
    localparam logic [FW-1:0] FLAST    = FW'(BLINK_DIV - 1);

    scan_state_e     state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic            wrap;

    logic            tmr_clr, tmr_ld, tmr_done, tmr_done_nxt;
    logic [TW-1:0]   tmr_val;

    digit_t          dig_q [N_DIG];
    digit_t          cur;

    logic [3:0]       data_d;
    logic [1:0]       mode_d;
    logic             en_d, fd_d;
    logic [N_DIG-1:0] sel_d;

    seg_cyc_timer #(.W(TW)) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (tmr_clr),
        .ld_i       (tmr_ld),
        .ld_val_i   (tmr_val),
        .done_o     (tmr_done),
        .done_nxt_o (tmr_done_nxt)
    );

    // Digit register file; writes land on the next edge regardless of scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIG; i++)
                dig_q[i] <= DIGIT_RST;
        end else if (wr_en_i && (32'(wr_addr_i) < N_DIG)) begin
            dig_q[wr_addr_i[PW-1:0]] <= '{data: wr_data_i, mode: wr_mode_i, blink: wr_blink_i};
        end
    end

    // Scan FSM next state; dropping run aborts from anywhere
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tmr_clr = 1'b0;
        tmr_ld  = 1'b0;
        tmr_val = SHOW_LD;
        wrap    = 1'b0;
        unique case (state_q)
            IDLE: if (run_i) begin
                state_d = SHOW;
                ptr_d   = '0;
                tmr_ld  = 1'b1;
                tmr_val = SHOW_LD;
            end
            SHOW: if (tmr_done) begin
                state_d = BLANK;
                tmr_ld  = 1'b1;
                tmr_val = BLANK_LD;
            end
            BLANK: if (tmr_done) begin
                state_d = SHOW;
                tmr_ld  = 1'b1;
                tmr_val = SHOW_LD;
                if (ptr_q == LAST) begin
                    ptr_d = '0;
                    wrap  = 1'b1;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!run_i) begin
            state_d = IDLE;
            ptr_d   = '0;
            tmr_clr = 1'b1;
            tmr_ld  = 1'b0;
            wrap    = 1'b0;
        end
    end

    // Frame counter and blink phase advance only on a completed frame
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == FLAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Output next values derived from the upcoming state so every output is a flop.
    // Data/mode/enable are captured only on SHOW entry, so mid-show writes wait.
    always_comb begin
        sel_d  = '1;
        en_d   = 1'b0;
        data_d = dec_data_o;
        mode_d = dec_mode_o;
        fd_d   = 1'b0;
        cur    = dig_q[ptr_d];
        case (state_d)
            IDLE: begin
                data_d = '0;
                mode_d = MODE_DEC_OFF;
            end
            SHOW: begin
                sel_d[ptr_d] = 1'b0;
                if (state_q != SHOW) begin
                    data_d = cur.data;
                    mode_d = cur.mode;
                    en_d   = ~(cur.blink & phase_d);
                end else begin
                    en_d = dec_en_o;
                end
            end
            BLANK: fd_d = (ptr_d == LAST) && tmr_done_nxt;
            default: ;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel_n_o  <= '1;
            dec_en_o     <= 1'b0;
            dec_data_o   <= '0;
            dec_mode_o   <= MODE_DEC_OFF;
            frame_done_o <= 1'b0;
        end else begin
            dig_sel_n_o  <= sel_d;
            dec_en_o     <= en_d;
            dec_data_o   <= data_d;
            dec_mode_o   <= mode_d;
            frame_done_o <= fd_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a time-indexed reference model.
module tb_seg_scan_ctrl;

    localparam int ND = 4, SD = 8, BC = 2, BD = 2;
    localparam int P  = SD + BC;
    localparam int FP = ND * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [1:0] wr_mode = '0;
    logic       wr_blink = 1'b0;
    logic [3:0] dec_data;
    logic [1:0] dec_mode;
    logic       dec_en;
    logic [3:0] dig_sel_n;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    seg_scan_ctrl #(.N_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_mode_i    (wr_mode),
        .wr_blink_i   (wr_blink),
        .dec_data_o   (dec_data),
        .dec_mode_o   (dec_mode),
        .dec_en_o     (dec_en),
        .dig_sel_n_o  (dig_sel_n),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: k = cycles since scanning (re)started; digit, position
    // and blink phase follow from plain arithmetic on k and completed frames.
    bit         active = 1'b0;
    int         k = 0;
    int         frames = 0;
    int         mdata [ND];
    int         mmode [ND];
    bit         mblink [ND];
    int         lat_data = 0, lat_mode = 1;
    bit         lat_en = 1'b0;
    logic [3:0] e_sel = 4'hF, e_data = 4'h0;
    logic [1:0] e_mode = 2'b01;
    logic       e_en = 1'b0, e_fd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int d, pos;
        if (!rst_n) begin
            active = 1'b0; k = 0; frames = 0;
            for (int i = 0; i < ND; i++) begin
                mdata[i] = 0; mmode[i] = 1; mblink[i] = 1'b0;
            end
            e_sel = 4'hF; e_en = 1'b0; e_data = 4'h0; e_mode = 2'b01; e_fd = 1'b0;
        end else begin
            if (!run) begin
                active = 1'b0;
                e_sel = 4'hF; e_en = 1'b0; e_data = 4'h0; e_mode = 2'b01; e_fd = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1; k = 0;
                end else begin
                    if (k % FP == FP - 1) frames++;
                    k++;
                end
                d   = (k / P) % ND;
                pos = k % P;
                if (pos == 0) begin
                    lat_data = mdata[d];
                    lat_mode = mmode[d];
                    lat_en   = !(mblink[d] && (((frames / BD) % 2) == 1));
                end
                e_data = 4'(lat_data);
                e_mode = 2'(lat_mode);
                e_sel  = 4'hF;
                if (pos < SD) begin
                    e_sel[d] = 1'b0;
                    e_en = lat_en;
                    e_fd = 1'b0;
                end else begin
                    e_en = 1'b0;
                    e_fd = (d == ND - 1) && (pos == P - 1);
                end
            end
            if (wr_en && wr_addr < 3'(ND)) begin
                mdata[wr_addr[1:0]]  = int'(wr_data);
                mmode[wr_addr[1:0]]  = int'(wr_mode);
                mblink[wr_addr[1:0]] = wr_blink;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("sel", 32'(dig_sel_n), 32'(e_sel));
        chk("en", 32'(dec_en), 32'(e_en));
        chk("data", 32'(dec_data), 32'(e_data));
        chk("mode", 32'(dec_mode), 32'(e_mode));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int dt, input int m, input bit b);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(dt); wr_mode = 2'(m); wr_blink = b;
        cyc(1);
        wr_en = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("lit_rst_sel", 32'(dig_sel_n), 32'hF);
        chk("lit_rst_mode", 32'(dec_mode), 32'h1);

        // Scan order
        for (int i = 0; i < ND; i++) wr(i, i + 1, 3, 1'b0);
        run = 1'b1;
        cyc(1);                                                  // k=0
        chk("lit_d0_sel", 32'(dig_sel_n), 32'hE);
        chk("lit_d0_data", 32'(dec_data), 32'h1);
        cyc(8);                                                  // k=8
        chk("lit_gap_sel", 32'(dig_sel_n), 32'hF);
        chk("lit_gap_en", 32'(dec_en), 32'h0);
        cyc(2);                                                  // k=10
        chk("lit_d1_sel", 32'(dig_sel_n), 32'hD);
        chk("lit_d1_data", 32'(dec_data), 32'h2);
        cyc(29);                                                 // k=39
        chk("lit_fd_hi", 32'(frame_done), 32'h1);
        cyc(1);                                                  // k=40
        chk("lit_fd_lo", 32'(frame_done), 32'h0);
        chk("lit_wrap_sel", 32'(dig_sel_n), 32'hE);

        // Live write during digit 1 SHOW, then an out-of-range write
        cyc(10);                                                 // k=50
        wr(1, 9, 3, 1'b0);                                       // k=51
        chk("lit_live_hold", 32'(dec_data), 32'h2);
        wr(5, 15, 0, 1'b1);                                      // k=52
        cyc(38);                                                 // k=90
        chk("lit_live_new", 32'(dec_data), 32'h9);
        chk("lit_live_mode", 32'(dec_mode), 32'h3);

        // Blink on digit 2
        wr(2, 3, 3, 1'b1);                                       // k=91
        cyc(9);                                                  // k=100, frame 2
        chk("lit_blink_sel", 32'(dig_sel_n), 32'hB);
        chk("lit_blink_off", 32'(dec_en), 32'h0);
        cyc(80);                                                 // k=180, frame 4
        chk("lit_blink_on", 32'(dec_en), 32'h1);

        // Stop in digit 2 BLANK, restart
        cyc(8);                                                  // k=188
        run = 1'b0;
        cyc(1);
        chk("lit_idle_sel", 32'(dig_sel_n), 32'hF);
        chk("lit_idle_data", 32'(dec_data), 32'h0);
        chk("lit_idle_mode", 32'(dec_mode), 32'h1);
        cyc(3);
        run = 1'b1;
        cyc(1);                                                  // k=0
        chk("lit_rs_sel0", 32'(dig_sel_n), 32'hE);
        cyc(7);                                                  // k=7
        chk("lit_rs_sel7", 32'(dig_sel_n), 32'hE);
        cyc(1);                                                  // k=8
        chk("lit_rs_gap", 32'(dig_sel_n), 32'hF);

        // Write digit 0 on its SHOW-entry edge
        cyc(31);                                                 // k=39
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd7; wr_mode = 2'd3; wr_blink = 1'b0;
        cyc(1);                                                  // k=40
        wr_en = 1'b0;
        chk("lit_same_old", 32'(dec_data), 32'h1);
        cyc(40);                                                 // k=80
        chk("lit_same_new", 32'(dec_data), 32'h7);

        // Asynchronous reset mid-SHOW
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_sel", 32'(dig_sel_n), 32'hF);
        chk("lit_arst_en", 32'(dec_en), 32'h0);
        chk("lit_arst_mode", 32'(dec_mode), 32'h1);
        chk("lit_arst_data", 32'(dec_data), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        run = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
